sc_io_input_conditioner: RTL and testbench

//  Conditions raw DE1-SoC switch/key pins before they reach sc_computer_main's sw/key ports.
//  Per channel: 2-FF synchronizer, counter debouncer, and (keys only) a sticky press flag the CPU clears.

---
 rtl/sc_io_input_conditioner_pkg.sv | 19 +
 rtl/sc_io_input_conditioner_debounce.sv | 64 ++++++
 rtl/sc_io_input_conditioner.sv | 70 +++++++
 tb/tb_sc_io_input_conditioner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sc_io_input_conditioner_pkg.sv
// Shared constants for the DE1-SoC switch/key input conditioner: pin counts,
// key polarity and the debounce lengths used on hardware and in simulation.
package sc_io_input_conditioner_pkg;

  localparam int N_SW  = 10;
  localparam int N_KEY = 3;

  // DE1-SoC push buttons pull the pin low when pressed.
  localparam logic KEY_ACTIVE_LEVEL = 1'b0;

  // 10 ms at 50 MHz on the board; a short count keeps simulation fast.
  localparam int DEBOUNCE_CYCLES_HW  = 500000;
  localparam int DEBOUNCE_CYCLES_SIM = 4;

  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sc_io_input_conditioner_debounce.sv
// One conditioned input: 2-FF synchronizer followed by a counter debouncer.
// accept_o is high in the cycle whose rising edge updates clean_o.
module io_debounce_channel
  import sc_io_input_conditioner_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter logic SYNC_RST_VAL    = 1'b0,
  parameter logic INVERT          = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw_i,
  output logic clean_o,
  output logic accept_o
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          clean_q;
  logic          clean_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level;
  logic          accept;

  // Inversion happens after the synchronizer so the flops see the raw pin.
  assign level = sync2_q ^ INVERT;

  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    accept  = 1'b0;
    if (level == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      clean_d = level;
      cnt_d   = '0;
      accept  = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= SYNC_RST_VAL;
      sync2_q <= SYNC_RST_VAL;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean_o  = clean_q;
  assign accept_o = accept;

endmodule

// File: rtl/sc_io_input_conditioner.sv
// Conditions raw DE1-SoC switch and key pins for the computer top level:
// per-channel synchronize + debounce, plus a CPU-clearable sticky press flag per key.
module sc_io_input_conditioner
  import sc_io_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_KEY-1:0] key_raw,
  input  logic [N_KEY-1:0] key_press_clr,
  output logic [N_SW-1:0]  sw_clean,
  output logic [N_KEY-1:0] key_clean,
  output logic [N_KEY-1:0] key_press
);

  logic [N_SW-1:0]  sw_accept;
  logic [N_KEY-1:0] key_accept;
  logic [N_KEY-1:0] key_rise;
  logic [N_KEY-1:0] key_press_q;
  logic [N_KEY-1:0] key_press_d;
  logic             unused_sw_accept;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    io_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_RST_VAL    (1'b0),
      .INVERT          (1'b0)
    ) u_chan (
      .clock    (clock),
      .resetn   (resetn),
      .raw_i    (sw_raw[i]),
      .clean_o  (sw_clean[i]),
      .accept_o (sw_accept[i])
    );
  end

  // Key synchronizers reset to the released pin level so no press is seen at reset exit.
  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    io_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_RST_VAL    (~KEY_ACTIVE_LEVEL),
      .INVERT          (KEY_ACTIVE_LEVEL == 1'b0)
    ) u_chan (
      .clock    (clock),
      .resetn   (resetn),
      .raw_i    (key_raw[i]),
      .clean_o  (key_clean[i]),
      .accept_o (key_accept[i])
    );
  end

  assign unused_sw_accept = &{1'b0, sw_accept};

  // A press edge in the same cycle as a clear keeps the flag set so no press is lost.
  assign key_rise    = key_accept & ~key_clean;
  assign key_press_d = key_rise | (key_press_q & ~key_press_clr);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_press_q <= '0;
    end else begin
      key_press_q <= key_press_d;
    end
  end

  assign key_press = key_press_q;

endmodule

// File: tb/tb_sc_io_input_conditioner.sv
// Directed bench for the input conditioner with a 4-cycle debounce: a vector
// table for steady-state behaviour plus hand sequences for glitches, bounce and reset.
module tb_sc_io_input_conditioner;
  import sc_io_input_conditioner_pkg::*;

  logic             clock = 1'b0;
  logic             resetn;
  logic [N_SW-1:0]  sw_raw;
  logic [N_KEY-1:0] key_raw;
  logic [N_KEY-1:0] key_press_clr;
  logic [N_SW-1:0]  sw_clean;
  logic [N_KEY-1:0] key_clean;
  logic [N_KEY-1:0] key_press;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [9:0] sw;
    logic [2:0] key;
    logic [2:0] clr;
    int         n;
    logic [9:0] e_sw;
    logic [2:0] e_kc;
    logic [2:0] e_kp;
  } vec_t;

  vec_t tbl[16];

  sc_io_input_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .sw_raw        (sw_raw),
    .key_raw       (key_raw),
    .key_press_clr (key_press_clr),
    .sw_clean      (sw_clean),
    .key_clean     (key_clean),
    .key_press     (key_press)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [9:0] e_sw,
                           input logic [2:0] e_kc, input logic [2:0] e_kp);
    check({name, ".sw_clean"},  32'(sw_clean),  32'(e_sw));
    check({name, ".key_clean"}, 32'(key_clean), 32'(e_kc));
    check({name, ".key_press"}, 32'(key_press), 32'(e_kp));
  endtask

  // Pulse sw_raw[0] high for len samples, watch 16 edges for rising clean edges.
  task automatic pulse_sw0(input int len, input int exp_rises, input int exp_at);
    int   rises;
    int   rise_at;
    logic prev;
    rises   = 0;
    rise_at = -1;
    prev    = sw_clean[0];
    for (int i = 1; i <= 16; i++) begin
      sw_raw[0] = (i <= len);
      step();
      if (sw_clean[0] && !prev) begin
        rises++;
        rise_at = i;
      end
      prev = sw_clean[0];
    end
    check($sformatf("pulse%0d.rises", len),   32'(rises),       32'(exp_rises));
    check($sformatf("pulse%0d.rise_at", len), 32'(rise_at),     32'(exp_at));
    check($sformatf("pulse%0d.final", len),   32'(sw_clean[0]), 32'd0);
  endtask

  initial begin
    // Hand-computed vectors, continuing from the state after the reset-exit test.
    tbl[0]  = '{10'h3FF, 3'b000, 3'b111, 1, 10'h3FF, 3'b111, 3'b000};
    tbl[1]  = '{10'h000, 3'b111, 3'b000, 5, 10'h3FF, 3'b111, 3'b000};
    tbl[2]  = '{10'h000, 3'b111, 3'b000, 1, 10'h000, 3'b000, 3'b000};
    tbl[3]  = '{10'h000, 3'b110, 3'b000, 5, 10'h000, 3'b000, 3'b000};
    tbl[4]  = '{10'h000, 3'b110, 3'b000, 1, 10'h000, 3'b001, 3'b001};
    tbl[5]  = '{10'h000, 3'b110, 3'b001, 1, 10'h000, 3'b001, 3'b000};
    tbl[6]  = '{10'h000, 3'b110, 3'b000, 3, 10'h000, 3'b001, 3'b000};
    tbl[7]  = '{10'h2A5, 3'b110, 3'b000, 5, 10'h000, 3'b001, 3'b000};
    tbl[8]  = '{10'h2A5, 3'b110, 3'b000, 1, 10'h2A5, 3'b001, 3'b000};
    tbl[9]  = '{10'h15A, 3'b100, 3'b000, 6, 10'h15A, 3'b011, 3'b010};
    tbl[10] = '{10'h15A, 3'b111, 3'b000, 6, 10'h15A, 3'b000, 3'b010};
    tbl[11] = '{10'h15A, 3'b101, 3'b000, 5, 10'h15A, 3'b000, 3'b010};
    tbl[12] = '{10'h15A, 3'b101, 3'b010, 1, 10'h15A, 3'b010, 3'b010};
    tbl[13] = '{10'h15A, 3'b101, 3'b010, 1, 10'h15A, 3'b010, 3'b000};
    tbl[14] = '{10'h15A, 3'b101, 3'b010, 1, 10'h15A, 3'b010, 3'b000};
    tbl[15] = '{10'h000, 3'b111, 3'b000, 6, 10'h000, 3'b000, 3'b000};

    // Reset with every pin in its active state; outputs must stay 0.
    resetn        = 1'b0;
    sw_raw        = 10'h3FF;
    key_raw       = 3'b000;
    key_press_clr = 3'b000;
    step();
    step();
    check_all("reset", 10'h000, 3'b000, 3'b000);

    // Release between edges: the next edge is the first sampling edge (edge 0),
    // so the accepted levels appear after the sixth edge.
    resetn = 1'b1;
    for (int e = 0; e < 5; e++) begin
      step();
      check_all($sformatf("exit.e%0d", e), 10'h000, 3'b000, 3'b000);
    end
    step();
    check_all("exit.e5", 10'h3FF, 3'b111, 3'b111);

    for (int v = 0; v < 16; v++) begin
      sw_raw        = tbl[v].sw;
      key_raw       = tbl[v].key;
      key_press_clr = tbl[v].clr;
      for (int c = 0; c < tbl[v].n; c++) step();
      check_all($sformatf("vec%0d", v), tbl[v].e_sw, tbl[v].e_kc, tbl[v].e_kp);
    end
    key_press_clr = 3'b000;

    // Glitches: a level must be seen for 4 consecutive samples to qualify,
    // so 2 and 3 samples are rejected and 4 or 5 are accepted once.
    pulse_sw0(2, 0, -1);
    pulse_sw0(3, 0, -1);
    pulse_sw0(4, 1, 6);
    pulse_sw0(5, 1, 6);

    // KEY3 bounces every 2 cycles for 20 cycles, then holds pressed.
    begin
      int   kc_rises;
      int   kp_rises;
      int   rise_at;
      logic kc_prev;
      logic kp_prev;
      kc_rises = 0;
      kp_rises = 0;
      rise_at  = -1;
      kc_prev  = key_clean[2];
      kp_prev  = key_press[2];
      for (int i = 0; i < 32; i++) begin
        key_raw[2] = (i < 20) ? logic'((i / 2) % 2) : 1'b0;
        step();
        if (key_clean[2] && !kc_prev) begin
          kc_rises++;
          rise_at = i - 19;
        end
        if (key_press[2] && !kp_prev) kp_rises++;
        kc_prev = key_clean[2];
        kp_prev = key_press[2];
      end
      check("bounce.kc_rises", 32'(kc_rises), 32'd1);
      check("bounce.kp_rises", 32'(kp_rises), 32'd1);
      check("bounce.rise_at",  32'(rise_at),  32'd6);
      check_all("bounce.final", 10'h000, 3'b100, 3'b100);
    end

    // Reset pulse while the switches are two counts into qualification.
    sw_raw  = 10'h3FF;
    key_raw = 3'b000;
    for (int c = 0; c < 4; c++) step();
    check_all("midcount.pre", 10'h000, 3'b100, 3'b100);
    resetn = 1'b0;
    #1;
    check_all("midcount.async", 10'h000, 3'b000, 3'b000);
    step();
    check_all("midcount.held", 10'h000, 3'b000, 3'b000);
    resetn = 1'b1;
    for (int e = 0; e < 5; e++) begin
      step();
      check_all($sformatf("requal.e%0d", e), 10'h000, 3'b000, 3'b000);
    end
    step();
    check_all("requal.e5", 10'h3FF, 3'b111, 3'b111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
